// File: rtl/vjtag_dr_bank.sv
// vjtag_dr_bank: multi-channel virtual-JTAG data-register bank.
// Each channel k is selected by virtual IR code k+1; every other code selects
// a one-bit bypass register. A capture loads readback data, a shift moves data
// LSB-first from tdi to tdo, and an update commits the shift register into the
// selected channel's output register with a one-cycle strobe.
// Optional feature macro: VJTAG_LEN_CHECK_EN -- when defined, an update commits
// only after exactly WIDTH shift cycles; otherwise it is rejected and the
// sticky len_err flag is set.
module vjtag_dr_bank #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int IR_W   = 3
) (
  input  logic                      tck,
  input  logic                      reset,
  input  logic [IR_W-1:0]           ir_in,
  input  logic                      v_cdr,
  input  logic                      v_sdr,
  input  logic                      v_udr,
  input  logic                      tdi,
  output logic                      tdo,
  input  logic [NUM_CH*WIDTH-1:0]   cap_data,
  output logic [NUM_CH*WIDTH-1:0]   out_reg,
  output logic [NUM_CH-1:0]         upd_stb,
  output logic                      len_err
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Shared shift register, bypass bit and latched selection.
  logic [WIDTH-1:0]        sh_q, sh_d;
  logic                    byp_q, byp_d;
  logic                    sel_byp_q, sel_byp_d;   // 1 = bypass selected
  logic [IDX_W-1:0]        sel_idx_q, sel_idx_d;   // channel index when not bypass
  logic [NUM_CH*WIDTH-1:0] out_q, out_d;
  logic [NUM_CH-1:0]       upd_stb_q, upd_stb_d;
  logic                    len_err_q, len_err_d;

  // IR decode: codes 1..NUM_CH map to channels 0..NUM_CH-1.
  logic                    ir_valid_s;
  logic [IDX_W-1:0]        ir_idx_s;
  logic                    len_ok_s;

  assign ir_valid_s = (ir_in != {IR_W{1'b0}}) &&
                      ({1'b0, ir_in} <= (IR_W+1)'(NUM_CH));
  assign ir_idx_s   = IDX_W'(ir_in - IR_W'(1));

`ifdef VJTAG_LEN_CHECK_EN
  localparam int CNT_W = $clog2(WIDTH + 2);

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  // Shift-length counter: cleared on capture, counts shifts, saturates at WIDTH+1.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (v_cdr) begin
      bit_cnt_d = {CNT_W{1'b0}};
    end else if (v_sdr) begin
      if (bit_cnt_q != CNT_W'(WIDTH + 1)) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Shift-length counter register.
  always_ff @(posedge tck) begin
    if (reset) begin
      bit_cnt_q <= {CNT_W{1'b0}};
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign len_ok_s = (bit_cnt_q == CNT_W'(WIDTH));
`else
  assign len_ok_s = 1'b1;
`endif

  // Capture / shift / update next-state logic with priority cdr > sdr > udr.
  always_comb begin
    sh_d      = sh_q;
    byp_d     = byp_q;
    sel_byp_d = sel_byp_q;
    sel_idx_d = sel_idx_q;
    out_d     = out_q;
    upd_stb_d = {NUM_CH{1'b0}};
    len_err_d = len_err_q;
    if (v_cdr) begin
      if (ir_valid_s) begin
        sel_byp_d = 1'b0;
        sel_idx_d = ir_idx_s;
        for (int k = 0; k < NUM_CH; k++) begin
          if (ir_idx_s == IDX_W'(k)) begin
            sh_d = cap_data[k*WIDTH +: WIDTH];
          end else begin
            sh_d = sh_d;
          end
        end
      end else begin
        sel_byp_d = 1'b1;
        byp_d     = 1'b0;
      end
    end else if (v_sdr) begin
      if (sel_byp_q) begin
        byp_d = tdi;
      end else begin
        sh_d = {tdi, sh_q[WIDTH-1:1]};
      end
    end else if (v_udr) begin
      if (sel_byp_q) begin
        out_d = out_q;
      end else if (len_ok_s) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (sel_idx_q == IDX_W'(k)) begin
            out_d[k*WIDTH +: WIDTH] = sh_q;
            upd_stb_d[k]            = 1'b1;
          end else begin
            upd_stb_d[k] = 1'b0;
          end
        end
      end else begin
        len_err_d = 1'b1;
      end
    end else begin
      sh_d = sh_q;
    end
  end

  // State registers; reset returns the bank to bypass with all outputs cleared.
  always_ff @(posedge tck) begin
    if (reset) begin
      sh_q      <= {WIDTH{1'b0}};
      byp_q     <= 1'b0;
      sel_byp_q <= 1'b1;
      sel_idx_q <= {IDX_W{1'b0}};
      out_q     <= {(NUM_CH*WIDTH){1'b0}};
      upd_stb_q <= {NUM_CH{1'b0}};
      len_err_q <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      byp_q     <= byp_d;
      sel_byp_q <= sel_byp_d;
      sel_idx_q <= sel_idx_d;
      out_q     <= out_d;
      upd_stb_q <= upd_stb_d;
      len_err_q <= len_err_d;
    end
  end

  assign tdo     = sel_byp_q ? byp_q : sh_q[0];
  assign out_reg = out_q;
  assign upd_stb = upd_stb_q;
  assign len_err = len_err_q;

endmodule
